// File: rtl/tdm_bus_sampler_pkg.sv
// Shared definitions for the TDM bus receive path.
//  - state_e       : lock state of the sampler (hunting for sync / locked and running)
//  - TdmNslots     : default slot count per frame
//  - TDelay*       : common slot lengths in clocks at a 12 MHz system clock
//  - width_of()    : counter width for a 0..range-1 counter, never less than one bit
package tdm_bus_sampler_pkg;

  typedef enum logic [0:0] {
    StHunt = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam int unsigned TdmNslots = 3;

  // Slot lengths, matching the LED divider values used elsewhere on the board.
  localparam int unsigned TDelay1s   = 12_000_000;
  localparam int unsigned TDelay1ms  = 12_000;
  localparam int unsigned TDelay1us  = 12;

  function automatic int unsigned width_of(input int unsigned range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_timer.sv
// Slot position timer for the TDM sampler.
// Tracks the position (slot, cnt) of the current cycle within a frame and the
// one-hot slot select.
// Ports:
//  clk          in   system clock
//  rst          in   synchronous active-high reset
//  start        in   this cycle is position (0,0); next cycle is (0,1)
//  run          in   locked: advance the position every cycle
//  cnt          out  clock index within the slot, 0..DELAY-1
//  slot         out  slot index within the frame, 0..NSLOTS-1
//  sel          out  one-hot of slot while running, 0 otherwise
//  sample_tick  out  current cycle is the slot midpoint (cnt == DELAY/2)
//  frame_end    out  current cycle is the last cycle of the last slot
module tdm_slot_timer
  import tdm_bus_sampler_pkg::*;
#(
  parameter int unsigned NSLOTS = TdmNslots,
  parameter int unsigned DELAY  = TDelay1s
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          run,
  output logic [width_of(DELAY)-1:0]    cnt,
  output logic [width_of(NSLOTS)-1:0]   slot,
  output logic [NSLOTS-1:0]             sel,
  output logic                          sample_tick,
  output logic                          frame_end
);

  localparam int unsigned CntW  = width_of(DELAY);
  localparam int unsigned SlotW = width_of(NSLOTS);

  localparam logic [CntW-1:0]  CntLast  = CntW'(DELAY - 1);
  localparam logic [CntW-1:0]  CntMid   = CntW'(DELAY / 2);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(NSLOTS - 1);

  logic [CntW-1:0]   cnt_d;
  logic [SlotW-1:0]  slot_d;
  logic [NSLOTS-1:0] sel_d;

  always_comb begin
    cnt_d  = cnt;
    slot_d = slot;
    sel_d  = sel;
    if (start) begin
      // The start cycle itself is (0,0), so the following cycle is (0,1).
      cnt_d  = CntW'(1);
      slot_d = '0;
      sel_d  = NSLOTS'(1);
    end else if (run) begin
      if (cnt == CntLast) begin
        cnt_d = '0;
        if (slot == SlotLast) begin
          slot_d = '0;
          sel_d  = NSLOTS'(1);
        end else begin
          slot_d = slot + 1'b1;
          sel_d  = sel << 1;
        end
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end else begin
      cnt_d  = '0;
      slot_d = '0;
      sel_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      slot <= '0;
      sel  <= '0;
    end else begin
      cnt  <= cnt_d;
      slot <= slot_d;
      sel  <= sel_d;
    end
  end

  assign sample_tick = run && (cnt == CntMid);
  assign frame_end   = run && (cnt == CntLast) && (slot == SlotLast);

endmodule

// File: rtl/tdm_bus_sampler.sv
// Receive end of a shared 1-bit time-slotted bus. Locks to a frame-sync
// strobe, samples the bus at the midpoint of every slot and publishes the
// rebuilt NSLOTS-bit word once per frame.
// Ports:
//  clk          in   system clock
//  rst          in   synchronous active-high reset
//  bus_in       in   shared bus value, synchronous to clk
//  sync         in   1-cycle strobe marking cycle 0 of slot 0
//  data         out  last complete frame, data[i] sampled in slot i
//  frame_valid  out  1-cycle pulse when data updates
//  sel          out  one-hot current slot, 0 while unlocked
//  sync_err     out  1-cycle pulse after a sync that arrived off position (0,0)
module tdm_bus_sampler
  import tdm_bus_sampler_pkg::*;
#(
  parameter int unsigned NSLOTS = TdmNslots,
  parameter int unsigned DELAY  = TDelay1s
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bus_in,
  input  logic              sync,
  output logic [NSLOTS-1:0] data,
  output logic              frame_valid,
  output logic [NSLOTS-1:0] sel,
  output logic              sync_err
);

  localparam int unsigned CntW  = width_of(DELAY);
  localparam int unsigned SlotW = width_of(NSLOTS);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt;
  logic [SlotW-1:0]  slot;
  logic              sample_tick;
  logic              frame_end;
  logic              run;
  logic              misaligned;
  logic [NSLOTS-1:0] shadow_q, shadow_d;

  assign run = (state_q == StRun);

  // Any sync seen while running that does not land on (0,0) restarts the frame.
  assign misaligned = run && sync && ((cnt != '0) || (slot != '0));

  tdm_slot_timer #(
    .NSLOTS (NSLOTS),
    .DELAY  (DELAY)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .start       (sync),
    .run         (run),
    .cnt         (cnt),
    .slot        (slot),
    .sel         (sel),
    .sample_tick (sample_tick),
    .frame_end   (frame_end)
  );

  always_comb begin
    state_d = state_q;
    if ((state_q == StHunt) && sync) begin
      state_d = StRun;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    if (misaligned) begin
      shadow_d = '0;
    end else if (sample_tick) begin
      shadow_d[slot] = bus_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      shadow_q    <= '0;
      data        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      sync_err    <= misaligned;
      frame_valid <= frame_end && !misaligned;
      // shadow_d so a midpoint sample on the final cycle (DELAY=2) is included.
      if (frame_end && !misaligned) begin
        data <= shadow_d;
      end
    end
  end

endmodule

// File: tb/tb_tdm_bus_sampler.sv
module tb_tdm_bus_sampler;

  localparam int unsigned NSlots = 3;
  localparam int unsigned Delay  = 4;
  localparam int FrameLen = NSlots * Delay;

  logic              clk = 1'b0;
  logic              rst;
  logic              bus_in;
  logic              sync;
  logic [NSlots-1:0] data;
  logic              frame_valid;
  logic [NSlots-1:0] sel;
  logic              sync_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position of a cycle is (cycle - frame_start) mod FrameLen.
  int                cyc = 0;
  int                t0  = 0;
  bit                locked = 0;
  logic [NSlots-1:0] m_shadow = '0;
  logic [NSlots-1:0] e_data = '0;
  logic [NSlots-1:0] e_sel = '0;
  bit                e_fv = 0;
  bit                e_err = 0;

  tdm_bus_sampler #(
    .NSLOTS (NSlots),
    .DELAY  (Delay)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_in      (bus_in),
    .sync        (sync),
    .data        (data),
    .frame_valid (frame_valid),
    .sel         (sel),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit s, input bit b);
    int p, q;
    if (r) begin
      locked = 0; m_shadow = '0; e_data = '0; e_fv = 0; e_err = 0; e_sel = '0;
    end else if (!locked) begin
      e_fv = 0; e_err = 0;
      if (s) begin
        locked = 1; t0 = cyc; e_sel = NSlots'(1);
      end else begin
        e_sel = '0;
      end
    end else begin
      p = (cyc - t0) % FrameLen;
      if (s && p != 0) begin
        e_err = 1; e_fv = 0; m_shadow = '0; t0 = cyc;
      end else begin
        e_err = 0;
        if (p % Delay == Delay / 2) m_shadow[p / Delay] = b;
        e_fv = (p == FrameLen - 1);
        if (e_fv) e_data = m_shadow;
      end
      q = (cyc + 1 - t0) % FrameLen;
      e_sel = NSlots'(1) << (q / Delay);
    end
  endtask

  // Apply one cycle of inputs, then compare all outputs after the edge.
  task automatic step(input bit r, input bit s, input bit b);
    rst = r; sync = s; bus_in = b;
    model(r, s, b);
    @(posedge clk);
    #1;
    cyc++;
    check("data", 32'(data), 32'(e_data));
    check("frame_valid", 32'(frame_valid), 32'(e_fv));
    check("sel", 32'(sel), 32'(e_sel));
    check("sync_err", 32'(sync_err), 32'(e_err));
  endtask

  // One frame: bus carries pat[slot] at the midpoint, optional noise elsewhere.
  task automatic frame(input logic [NSlots-1:0] pat, input bit with_sync, input bit noise);
    bit b;
    for (int k = 0; k < FrameLen; k++) begin
      b = pat[k / Delay];
      if (noise && (k % Delay != Delay / 2)) b = ~b;
      step(1'b0, with_sync && (k == 0), b);
    end
  endtask

  initial begin
    bit r, s;
    rst = 1'b1; sync = 1'b0; bus_in = 1'b0;

    // Reset, then idle with a toggling bus and no sync.
    step(1, 0, 0);
    step(1, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 1'($urandom));
    check("idle_data", 32'(data), 32'h0);
    check("idle_sel", 32'(sel), 32'h0);

    // Lock, frame 1 = 101, frame 2 = 011 (bits 0,1,1 -> 110), with noise.
    frame(3'b101, 1, 0);
    check("frame1_valid", 32'(frame_valid), 32'h1);
    check("frame1_data", 32'(data), 32'h5);
    frame(3'b110, 1, 1);
    check("frame2_data", 32'(data), 32'h6);
    frame(3'b011, 0, 1);
    check("freerun_data", 32'(data), 32'h3);

    // Misaligned sync at offset 5 of a frame.
    for (int k = 0; k < 6; k++) step(0, (k == 5), 1'($urandom));
    check("misalign_err", 32'(sync_err), 32'h1);
    for (int k = 0; k < 11; k++) step(0, 0, 1'($urandom));
    check("misalign_fv", 32'(frame_valid), 32'h1);

    // Reset mid-frame, then relock.
    for (int k = 0; k < 6; k++) step(0, 0, 1'($urandom));
    step(1, 0, 1);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    for (int k = 0; k < 7; k++) step(0, 0, 1'($urandom));
    frame(3'b111, 1, 1);
    check("relock_data", 32'(data), 32'h7);

    // Random traffic: mostly aligned syncs, occasional stray syncs and resets.
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 39) == 0) ||
          (locked && ((cyc - t0) % FrameLen == 0) && ($urandom_range(0, 1) == 1));
      step(r, s, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
